regfile_wb_sink: RTL and testbench

- Write-back receiving end of the MIPS-lite no-forwarding pipeline: the architectural register file that consumes wbData/wbRd from the write-back stage.
- Serves decode-stage reads through two read ports with same-cycle write-through.
- Keeps a per-register pending-write scoreboard that raises stall for RAW hazards, since this pipeline has no forwarding.
- Drains in-flight writes on halt before signalling completion.

---
 rtl/regfile_wb_sink.sv | 115 +++++++++++
 tb/tb_regfile_wb_sink.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_wb_sink.sv
// Architectural register file at the write-back end of the no-forwarding pipeline.
// Two combinational read ports with write-through of the current write-back, a
// per-register pending-write scoreboard that drives the RAW stall, and halt drain.
module regfile_wb_sink #(
  parameter int unsigned DATA          = 32,
  parameter int unsigned REGISTERWIDTH = 5,
  parameter int unsigned REGCOUNT      = 2 ** REGISTERWIDTH,
  parameter int unsigned PENDW         = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wbEn,
  input  logic [REGISTERWIDTH-1:0] wbRd,
  input  logic [DATA-1:0]          wbData,
  input  logic [REGISTERWIDTH-1:0] rs,
  input  logic [REGISTERWIDTH-1:0] rt,
  input  logic                     useRs,
  input  logic                     useRt,
  input  logic                     issueValid,
  input  logic                     issueWrites,
  input  logic [REGISTERWIDTH-1:0] issueRd,
  input  logic                     haltIn,
  output logic [DATA-1:0]          rsData,
  output logic [DATA-1:0]          rtData,
  output logic                     stall,
  output logic                     drained
);

  localparam logic [PENDW-1:0] CntMax = '1;
  localparam logic [PENDW-1:0] CntOne = PENDW'(1);

  logic [DATA-1:0]  regs_q [REGCOUNT];
  logic [PENDW-1:0] cnt_q  [REGCOUNT];
  logic [PENDW-1:0] cnt_d  [REGCOUNT];
  logic             halt_seen_q, halt_seen_d;
  logic             drained_q, drained_d;

  logic             wb_live;
  logic [PENDW-1:0] eff_rs, eff_rt;
  logic             haz_rs, haz_rt, haz_sat;
  logic             accept, inc;
  logic             all_zero_d;

  // A write-back to $0 is architecturally a no-op: no data, no retire.
  assign wb_live = wbEn && (wbRd != '0);

  // Read ports with write-through; $0 is hardwired to zero and reset forces zero.
  always_comb begin
    rsData = '0;
    rtData = '0;
    if (!reset && rs != '0) rsData = (wbEn && wbRd == rs) ? wbData : regs_q[rs];
    if (!reset && rt != '0) rtData = (wbEn && wbRd == rt) ? wbData : regs_q[rt];
  end

  // Hazard detection: a producer retiring this cycle no longer counts as pending.
  always_comb begin
    eff_rs  = cnt_q[rs] - PENDW'(wbEn && wbRd == rs);
    eff_rt  = cnt_q[rt] - PENDW'(wbEn && wbRd == rt);
    haz_rs  = useRs && (rs != '0) && (eff_rs != '0);
    haz_rt  = useRt && (rt != '0) && (eff_rt != '0);
    // Saturation uses the raw count so a counter can never wrap.
    haz_sat = issueWrites && (issueRd != '0) && (cnt_q[issueRd] == CntMax);
    stall   = !reset && (halt_seen_q || (issueValid && (haz_rs || haz_rt || haz_sat)));
    accept  = issueValid && !stall;
    inc     = accept && issueWrites && (issueRd != '0);
  end

  // Scoreboard next state: issue increments, retire decrements, both cancel out.
  always_comb begin
    all_zero_d = 1'b1;
    for (int r = 0; r < int'(REGCOUNT); r++) begin
      logic inc_r, dec_r;
      inc_r    = inc && (issueRd == REGISTERWIDTH'(r));
      dec_r    = wb_live && (wbRd == REGISTERWIDTH'(r));
      cnt_d[r] = cnt_q[r];
      if (inc_r && !dec_r) begin
        cnt_d[r] = cnt_q[r] + CntOne;
      end else if (dec_r && !inc_r && cnt_q[r] != '0) begin
        cnt_d[r] = cnt_q[r] - CntOne;
      end
      if (cnt_d[r] != '0) all_zero_d = 1'b0;
    end
    halt_seen_d = halt_seen_q || (accept && haltIn);
    drained_d   = halt_seen_d && all_zero_d;
  end

  // Register array update from the write-back stage.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(REGCOUNT); r++) regs_q[r] <= '0;
    end else if (wb_live) begin
      regs_q[wbRd] <= wbData;
    end
  end

  // Scoreboard counters, sticky halt flag and registered drain indication.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < int'(REGCOUNT); r++) cnt_q[r] <= '0;
      halt_seen_q <= 1'b0;
      drained_q   <= 1'b0;
    end else begin
      for (int r = 0; r < int'(REGCOUNT); r++) cnt_q[r] <= cnt_d[r];
      halt_seen_q <= halt_seen_d;
      drained_q   <= drained_d;
    end
  end

  assign drained = drained_q;

  // A retire must always match an earlier issue to the same register.
  wb_has_pending_a: assert property (@(posedge clk) disable iff (reset)
    wb_live |-> (cnt_q[wbRd] != '0));

endmodule

// File: tb/tb_regfile_wb_sink.sv
// Self-checking bench for regfile_wb_sink: directed scenarios plus a randomized
// run, all compared against a behavioural register-file/scoreboard model.
module tb_regfile_wb_sink;

  localparam int NREG = 32;
  localparam int MAXP = 3;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbEn;
  logic [4:0]  wbRd;
  logic [31:0] wbData;
  logic [4:0]  rs, rt;
  logic        useRs, useRt;
  logic        issueValid, issueWrites;
  logic [4:0]  issueRd;
  logic        haltIn;
  logic [31:0] rsData, rtData;
  logic        stall, drained;

  int n_checks = 0;
  int n_errors = 0;

  // Behavioural model state
  logic [31:0] m_regs [NREG];
  int          m_cnt  [NREG];
  bit          m_halt;
  bit          m_drained;

  regfile_wb_sink dut (
    .clk        (clk),
    .reset      (reset),
    .wbEn       (wbEn),
    .wbRd       (wbRd),
    .wbData     (wbData),
    .rs         (rs),
    .rt         (rt),
    .useRs      (useRs),
    .useRt      (useRt),
    .issueValid (issueValid),
    .issueWrites(issueWrites),
    .issueRd    (issueRd),
    .haltIn     (haltIn),
    .rsData     (rsData),
    .rtData     (rtData),
    .stall      (stall),
    .drained    (drained)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1);
  end

  function automatic int m_eff(input int r);
    return m_cnt[r] - ((wbEn && int'(wbRd) == r) ? 1 : 0);
  endfunction

  function automatic bit m_stall();
    if (reset) return 1'b0;
    if (m_halt) return 1'b1;
    if (!issueValid) return 1'b0;
    if (useRs && rs != 0 && m_eff(int'(rs)) != 0) return 1'b1;
    if (useRt && rt != 0 && m_eff(int'(rt)) != 0) return 1'b1;
    if (issueWrites && issueRd != 0 && m_cnt[issueRd] == MAXP) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] r);
    if (reset || r == 0) return 32'h0;
    if (wbEn && wbRd == r) return wbData;
    return m_regs[r];
  endfunction

  task automatic model_reset();
    for (int r = 0; r < NREG; r++) begin
      m_regs[r] = 32'h0;
      m_cnt[r]  = 0;
    end
    m_halt    = 1'b0;
    m_drained = 1'b0;
  endtask

  // Advance the model with the current inputs, then clock the DUT.
  task automatic tick();
    bit acc, inc, dec, all_zero;
    if (reset) begin
      model_reset();
    end else begin
      acc = issueValid && !m_stall();
      inc = acc && issueWrites && issueRd != 0;
      dec = wbEn && wbRd != 0;
      if (dec) m_regs[wbRd] = wbData;
      if (!(inc && dec && issueRd == wbRd)) begin
        if (inc) m_cnt[issueRd]++;
        if (dec && m_cnt[wbRd] > 0) m_cnt[wbRd]--;
      end
      if (acc && haltIn) m_halt = 1'b1;
      all_zero = 1'b1;
      for (int r = 0; r < NREG; r++) if (m_cnt[r] != 0) all_zero = 1'b0;
      m_drained = m_halt && all_zero;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wbEn = 0; wbRd = 0; wbData = 0; rs = 0; rt = 0; useRs = 0; useRt = 0;
    issueValid = 0; issueWrites = 0; issueRd = 0; haltIn = 0;
  endtask

  task automatic issue_to(input logic [4:0] rd);
    idle();
    issueValid = 1; issueWrites = 1; issueRd = rd;
    tick();
  endtask

  task automatic test_reset();
    reset = 1;
    idle();
    model_reset();
    #2;
    n_checks++;
    if (rsData !== 32'h0 || rtData !== 32'h0 || stall !== 1'b0 || drained !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_outputs: got rs=%h rt=%h stall=%b drained=%b want all zero",
               rsData, rtData, stall, drained);
    end
    tick();
    reset = 0;
    issue_to(5);
    idle(); wbEn = 1; wbRd = 5; wbData = 32'h1234;
    tick();
    issue_to(5);
    issue_to(5);
    idle(); issueValid = 1; useRs = 1; rs = 5;
    #1;
    n_checks++;
    if (stall !== 1'b1 || rsData !== 32'h1234) begin
      n_errors++;
      $display("FAIL reset_preload: got stall=%b rs=%h want stall=1 rs=00001234", stall, rsData);
    end
    reset = 1;
    #1;
    n_checks++;
    if (rsData !== 32'h0 || stall !== 1'b0 || drained !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_midop: got rs=%h stall=%b drained=%b want 0 0 0",
               rsData, stall, drained);
    end
    tick();
    reset = 0;
    #1;
    n_checks++;
    if (rsData !== 32'h0 || stall !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_cleared: got rs=%h stall=%b want rs=0 stall=0", rsData, stall);
    end
    idle();
    tick();
  endtask

  task automatic test_raw();
    issue_to(3);
    idle(); issueValid = 1; useRs = 1; rs = 3;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_checks++;
      if (stall !== 1'b1) begin
        n_errors++;
        $display("FAIL raw_stall%0d: got stall=%b want 1", i, stall);
      end
      tick();
    end
    wbEn = 1; wbRd = 3; wbData = 32'hDEADBEEF;
    #1;
    n_checks++;
    if (stall !== 1'b0 || rsData !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL raw_resolve: got stall=%b rs=%h want stall=0 rs=deadbeef", stall, rsData);
    end
    tick();
    idle();
  endtask

  task automatic test_wb_zero();
    idle();
    wbEn = 1; wbRd = 0; wbData = 32'hFFFF_FFFF;
    issueValid = 1; useRs = 1; useRt = 1; rs = 0; rt = 3;
    #1;
    n_checks++;
    if (rsData !== 32'h0 || stall !== 1'b0 || rtData !== 32'hDEADBEEF) begin
      n_errors++;
      $display("FAIL wb_zero: got rs=%h rt=%h stall=%b want rs=0 rt=deadbeef stall=0",
               rsData, rtData, stall);
    end
    tick();
    wbEn = 0;
    #1;
    n_checks++;
    if (rsData !== 32'h0 || stall !== 1'b0) begin
      n_errors++;
      $display("FAIL wb_zero_after: got rs=%h stall=%b want 0 0", rsData, stall);
    end
    idle();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 3; i++) begin
      idle(); issueValid = 1; issueWrites = 1; issueRd = 7;
      #1;
      n_checks++;
      if (stall !== 1'b0) begin
        n_errors++;
        $display("FAIL sat_fill%0d: got stall=%b want 0", i, stall);
      end
      tick();
    end
    // Fourth issue stalls even with a retire to $7 in flight.
    idle(); issueValid = 1; issueWrites = 1; issueRd = 7;
    wbEn = 1; wbRd = 7; wbData = 32'h7777;
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_full: got stall=%b want 1", stall);
    end
    tick();
    // Count is 2: issue and retire together keep it at 2.
    #1;
    n_checks++;
    if (stall !== 1'b0) begin
      n_errors++;
      $display("FAIL sat_incdec: got stall=%b want 0", stall);
    end
    tick();
    idle(); issueValid = 1; issueWrites = 1; issueRd = 7;
    tick();
    #1;
    n_checks++;
    if (stall !== 1'b1) begin
      n_errors++;
      $display("FAIL sat_refill: got stall=%b want 1", stall);
    end
    for (int i = 0; i < 3; i++) begin
      idle(); wbEn = 1; wbRd = 7; wbData = 32'h700 + i;
      tick();
    end
    idle(); issueValid = 1; useRs = 1; rs = 7;
    #1;
    n_checks++;
    if (stall !== m_stall() || stall !== 1'b0 || rsData !== 32'h702) begin
      n_errors++;
      $display("FAIL sat_drained: got stall=%b rs=%h want stall=0 rs=00000702", stall, rsData);
    end
    idle();
  endtask

  task automatic test_halt();
    issue_to(2);
    issue_to(9);
    idle(); issueValid = 1; haltIn = 1;
    #1;
    n_checks++;
    if (stall !== 1'b0 || drained !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_accept: got stall=%b drained=%b want 0 0", stall, drained);
    end
    tick();
    idle(); issueValid = 1; issueWrites = 1; issueRd = 12;
    #1;
    n_checks++;
    if (stall !== 1'b1 || drained !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_stall: got stall=%b drained=%b want 1 0", stall, drained);
    end
    tick();
    idle(); wbEn = 1; wbRd = 2; wbData = 32'h22;
    tick();
    idle(); wbEn = 1; wbRd = 9; wbData = 32'h99;
    #1;
    n_checks++;
    if (drained !== 1'b0 || stall !== 1'b1) begin
      n_errors++;
      $display("FAIL halt_draining: got drained=%b stall=%b want 0 1", drained, stall);
    end
    tick();
    idle();
    #1;
    n_checks++;
    if (drained !== 1'b1 || stall !== 1'b1 || drained !== m_drained) begin
      n_errors++;
      $display("FAIL halt_drained: got drained=%b stall=%b want 1 1", drained, stall);
    end
    reset = 1;
    #1;
    n_checks++;
    if (drained !== 1'b0 || stall !== 1'b0) begin
      n_errors++;
      $display("FAIL halt_reset: got drained=%b stall=%b want 0 0", drained, stall);
    end
    tick();
    reset = 0;
  endtask

  task automatic test_write_through();
    issue_to(4);
    idle(); wbEn = 1; wbRd = 4; wbData = 32'h55; rs = 4; rt = 4;
    #1;
    n_checks++;
    if (rsData !== 32'h55 || rtData !== 32'h55) begin
      n_errors++;
      $display("FAIL wt_same_cycle: got rs=%h rt=%h want 55 55", rsData, rtData);
    end
    tick();
    wbEn = 0; wbData = 0;
    #1;
    n_checks++;
    if (rsData !== 32'h55 || rtData !== 32'h55) begin
      n_errors++;
      $display("FAIL wt_after_edge: got rs=%h rt=%h want 55 55", rsData, rtData);
    end
    idle();
  endtask

  task automatic test_random();
    int pend[$];
    int guard;
    bit busy;
    for (int cyc = 0; cyc < 400; cyc++) begin
      idle();
      issueValid  = 1'($urandom_range(0, 1));
      useRs       = 1'($urandom_range(0, 1));
      useRt       = 1'($urandom_range(0, 1));
      rs          = 5'($urandom_range(0, 7));
      rt          = 5'($urandom_range(0, 7));
      issueWrites = 1'($urandom_range(0, 1));
      issueRd     = 5'($urandom_range(0, 7));
      wbData      = $urandom;
      pend.delete();
      for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) pend.push_back(r);
      if (pend.size() > 0 && $urandom_range(0, 2) != 0) begin
        wbEn = 1;
        wbRd = 5'(pend[$urandom_range(0, pend.size() - 1)]);
      end else if ($urandom_range(0, 7) == 0) begin
        wbEn = 1;
        wbRd = 0;
      end
      #1;
      n_checks++;
      if (rsData !== m_read(rs) || rtData !== m_read(rt) || stall !== m_stall() ||
          drained !== m_drained) begin
        n_errors++;
        $display("FAIL rand_cyc%0d: got rs=%h rt=%h stall=%b drained=%b want %h %h %b %b",
                 cyc, rsData, rtData, stall, drained, m_read(rs), m_read(rt), m_stall(),
                 m_drained);
      end
      tick();
    end
    idle(); issueValid = 1; haltIn = 1;
    tick();
    guard = 0;
    busy  = 1'b1;
    while (busy && guard < 200) begin
      idle();
      pend.delete();
      for (int r = 1; r < NREG; r++) if (m_cnt[r] > 0) pend.push_back(r);
      busy = (pend.size() > 0);
      if (busy) begin
        wbEn = 1; wbRd = 5'(pend[0]); wbData = $urandom;
      end
      #1;
      n_checks++;
      if (drained !== m_drained || stall !== 1'b1) begin
        n_errors++;
        $display("FAIL rand_drain%0d: got drained=%b stall=%b want %b 1",
                 guard, drained, stall, m_drained);
      end
      tick();
      guard++;
    end
    #1;
    n_checks++;
    if (drained !== 1'b1) begin
      n_errors++;
      $display("FAIL rand_final_drained: got %b want 1", drained);
    end
  endtask

  initial begin
    test_reset();
    test_raw();
    test_wb_zero();
    test_saturation();
    test_halt();
    test_write_through();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
